// File: rtl/mp_add_seq.sv
// ---------------------------------------------------------------------------
// mp_add_seq -- multi-precision adder sequencer.
//
// Adds two WORDS*BIT-bit operands with one shared BIT-wide ripple adder
// (fa_nbit), one chunk per clock, LSB chunk first. The carry between chunks
// is held in a register. Requests and results use valid/ready handshakes.
//
// Optional build macro: MP_ADD_SEQ_OVF_EN adds ovf_o, the signed
// two's-complement overflow of the full-width add.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   in_valid_i   request carries valid operands
//   in_ready_o   block is idle and can accept a request
//   a_i, b_i     operands (BIT*WORDS bits)
//   cin_i        carry-in to chunk 0
//   out_valid_o  result available
//   out_ready_i  consumer accepts result
//   sum_o        result (BIT*WORDS bits)
//   cout_o       carry-out of the top chunk
//   ovf_o        signed overflow (only with MP_ADD_SEQ_OVF_EN)
// ---------------------------------------------------------------------------

// BIT-wide ripple-carry adder.
module fa_nbit #(
  parameter int BIT = 4
) (
  input  logic [BIT-1:0] a,
  input  logic [BIT-1:0] b,
  input  logic           cin,
  output logic [BIT-1:0] sum,
  output logic           cout
);
  logic [BIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < BIT; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[BIT];
endmodule

module mp_add_seq #(
  parameter int BIT   = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [BIT*WORDS-1:0] a_i,
  input  logic [BIT*WORDS-1:0] b_i,
  input  logic                 cin_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [BIT*WORDS-1:0] sum_o,
  output logic                 cout_o
`ifdef MP_ADD_SEQ_OVF_EN
  ,
  output logic                 ovf_o
`endif
);
  localparam int W  = BIT * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, nxt;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_reg, b_reg, sum_reg;
  logic          cout_reg;
  logic [BIT-1:0] ch_a, ch_b, ch_sum;
  logic          ch_cout;
  logic          last;

  assign ch_a = a_reg[idx*BIT +: BIT];
  assign ch_b = b_reg[idx*BIT +: BIT];
  assign last = (idx == LAST);

  fa_nbit #(.BIT(BIT)) u_add (
    .a    (ch_a),
    .b    (ch_b),
    .cin  (carry),
    .sum  (ch_sum),
    .cout (ch_cout)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= nxt;
  end

  // Next-state decode. Inputs only matter in the state that listens to them.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid_i)  nxt = RUN;
      RUN:     if (last)        nxt = DONE;
      DONE:    if (out_ready_i) nxt = IDLE;
      default:                  nxt = IDLE;
    endcase
  end

  // Datapath. sum_reg/cout_reg are only rewritten by a new operation, so the
  // last result stays on sum_o/cout_o after the output handshake.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            a_reg <= a_i;
            b_reg <= b_i;
            carry <= cin_i;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_reg[idx*BIT +: BIT] <= ch_sum;
          carry                   <= ch_cout;
          if (last) cout_reg <= ch_cout;
          else      idx      <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MP_ADD_SEQ_OVF_EN
  logic ovf_reg;
  logic cmsb;

  // Carry into the top bit recovered from that bit's sum: s = a ^ b ^ c.
  assign cmsb = ch_a[BIT-1] ^ ch_b[BIT-1] ^ ch_sum[BIT-1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                ovf_reg <= 1'b0;
    else if (state == RUN && last) ovf_reg <= cmsb ^ ch_cout;
  end

  assign ovf_o = ovf_reg;
`endif

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign sum_o       = sum_reg;
  assign cout_o      = cout_reg;
endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq at BIT=4, WORDS=4 (16-bit operands).
module tb_mp_add_seq;
  localparam int BIT   = 4;
  localparam int WORDS = 4;
  localparam int W     = BIT * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
`ifdef MP_ADD_SEQ_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mp_add_seq #(.BIT(BIT), .WORDS(WORDS)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .cin_i       (cin),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .cout_o      (cout)
`ifdef MP_ADD_SEQ_OVF_EN
    ,
    .ovf_o       (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    int           hold;   // cycles of out_ready=0 in DONE; 0 = ready held early
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_result(input string nm, input vec_t v);
    chk({nm, "_sum"}, 32'(sum), 32'(v.sum));
    chk({nm, "_cout"}, 32'(cout), 32'(v.cout));
`ifdef MP_ADD_SEQ_OVF_EN
    chk({nm, "_ovf"}, 32'(ovf), 32'(v.ovf));
`endif
  endtask

  // One full transaction. While the operation runs in_valid stays high with
  // junk operands, which the block must ignore.
  task automatic do_op(input vec_t v);
    int lat;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd1);
    a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
    out_ready = (v.hold == 0);
    @(posedge clk); #1;
    a = ~v.a; b = v.b ^ 16'h5a5a; cin = ~v.cin;
    chk("busy_ready", 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), 32'd5);
    chk_result("res", v);
    for (int k = 0; k < v.hold; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk_result("bp", v);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_ready", 32'(in_ready), 32'd1);
    chk("post_valid", 32'(out_valid), 32'd0);
    chk_result("post_hold", v);
  endtask

  initial begin
    int t1, t2, n;
    vec_t v;

    //        a         b         cin  hold sum       cout  ovf
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 0, 16'h5556, 1'b0, 1'b0};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 5, 16'h5556, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 2, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 0, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1, 16'h0001, 1'b0, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 0, 16'hBCDE, 1'b0, 1'b0};
    vecs[8] = '{16'h0F0F, 16'h00F1, 1'b0, 0, 16'h1000, 1'b0, 1'b0};
    vecs[9] = '{16'h4000, 16'h4000, 1'b0, 0, 16'h8000, 1'b0, 1'b1};

    // Reset state.
    #12;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) do_op(vecs[i]);

    // Reset between edges with idx=2: everything clears at once.
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_sum_nonzero", 32'(sum != 0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(vecs[8]);

    // Back-to-back with in_valid held and out_ready held.
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    t1 = cyc;
    a = 16'hFFFF; b = 16'hFFFF;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    v = '{16'h0001, 16'h0001, 1'b0, 0, 16'h0002, 1'b0, 1'b0};
    chk_result("b2b_first", v);
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    t2 = cyc;
    chk("b2b_accepted", 32'(in_ready), 32'd0);
    chk("b2b_period", 32'(t2 - t1), 32'd6);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    in_valid = 1'b0;
    v = '{16'hFFFF, 16'hFFFF, 1'b0, 0, 16'hFFFE, 1'b1, 1'b0};
    chk("b2b_second_valid", 32'(out_valid), 32'd1);
    chk_result("b2b_second", v);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_end_ready", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
